// File: rtl/uncached_write_buffer.sv
// ---------------------------------------------------------------------------
// uncached_write_buffer
//
// Posted-write buffer on the uncached SRAM-like path. Uncached stores are
// acknowledged as soon as they land in a small FIFO and are drained to the
// downstream port one at a time, oldest first. Uncached loads are accepted
// only once every buffered store has completed downstream, so MMIO ordering
// is strict. Upstream completions (s_data_ok) return in acceptance order.
//
// Ports
//   clk, resetn               clock, asynchronous active-low reset
//   s_req/s_wr/s_size/s_addr/s_wdata   upstream request (size: 0 B, 1 H, 2 W)
//   s_addr_ok                 upstream request accepted this cycle
//   s_data_ok/s_rdata         upstream completion pulse / load data
//   m_req/m_wr/m_size/m_addr/m_wdata   downstream request
//   m_addr_ok/m_data_ok/m_rdata        downstream handshakes / load data
//   drained                   FIFO empty and FSM idle (fence indication)
//
// Handshake semantics (both sides): a request transfers on a rising clock
// edge where req & addr_ok are both high; req and every request field are
// held stable until that edge. Each transferred request is later completed
// by exactly one single-cycle data_ok pulse, in transfer order. Only one
// downstream transaction is ever outstanding.
//
// The FSM state is held in state_q (type state_t) for observation.
// ---------------------------------------------------------------------------
module uncached_write_buffer #(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        s_req,
  input  logic        s_wr,
  input  logic [1:0]  s_size,
  input  logic [31:0] s_addr,
  input  logic [31:0] s_wdata,
  output logic        s_addr_ok,
  output logic        s_data_ok,
  output logic [31:0] s_rdata,
  output logic        m_req,
  output logic        m_wr,
  output logic [1:0]  m_size,
  output logic [31:0] m_addr,
  output logic [31:0] m_wdata,
  input  logic        m_addr_ok,
  input  logic        m_data_ok,
  input  logic [31:0] m_rdata,
  output logic        drained
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    DR_ADDR = 3'd1,
    DR_DATA = 3'd2,
    RD_ADDR = 3'd3,
    RD_DATA = 3'd4
  } state_t;

  state_t          state_q, state_d;
  logic [AW-1:0]   head_q, head_d;
  logic [AW-1:0]   tail_q, tail_d;
  logic [AW:0]     count_q, count_d;
  logic            wack_q, wack_d;
  logic [1:0]      rd_size_q, rd_size_d;
  logic [31:0]     rd_addr_q, rd_addr_d;

  // Store payload; no reset needed, an entry is only read after it is written.
  logic [1:0]      size_mem  [DEPTH];
  logic [31:0]     addr_mem  [DEPTH];
  logic [31:0]     wdata_mem [DEPTH];

  logic            wr_ok, rd_ok;
  logic            push, rd_hs, pop;

  // A write may enter whenever there is room and no load is in flight.
  // Room is judged on the registered count only: a pop in the same cycle
  // does not open a slot, which keeps s_addr_ok free of m_data_ok.
  // A load may enter only when the buffer is fully drained.
  always_comb begin
    wr_ok     = (count_q != FULL_CNT) && (state_q != RD_ADDR) && (state_q != RD_DATA);
    rd_ok     = (state_q == IDLE) && (count_q == '0);
    s_addr_ok = s_wr ? wr_ok : rd_ok;
  end

  assign push  = s_req & s_wr & wr_ok;
  assign rd_hs = s_req & ~s_wr & rd_ok;
  assign pop   = (state_q == DR_DATA) & m_data_ok;

  // Pointer, count, read-register and write-ack next state.
  always_comb begin
    head_d    = head_q;
    tail_d    = tail_q;
    count_d   = count_q;
    rd_size_d = rd_size_q;
    rd_addr_d = rd_addr_q;
    wack_d    = push;
    if (push) tail_d = tail_q + AW'(1);
    if (pop)  head_d = head_q + AW'(1);
    if (push && !pop)      count_d = count_q + (AW+1)'(1);
    else if (!push && pop) count_d = count_q - (AW+1)'(1);
    if (rd_hs) begin
      rd_size_d = s_size;
      rd_addr_d = s_addr;
    end
  end

  // FSM next state.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (count_q != '0) state_d = DR_ADDR;
        else if (rd_hs)    state_d = RD_ADDR;
      end
      DR_ADDR: if (m_addr_ok) state_d = DR_DATA;
      // count_d already folds in a push landing in the same cycle, so a
      // freshly posted store goes straight out without an IDLE bubble.
      DR_DATA: if (m_data_ok) state_d = (count_d != '0) ? DR_ADDR : IDLE;
      RD_ADDR: if (m_addr_ok) state_d = RD_DATA;
      RD_DATA: if (m_data_ok) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Downstream request: a pure decode of registered state and storage, so
  // it cannot change while waiting for m_addr_ok.
  always_comb begin
    m_req   = 1'b0;
    m_wr    = 1'b0;
    m_size  = 2'd0;
    m_addr  = 32'd0;
    m_wdata = 32'd0;
    case (state_q)
      DR_ADDR: begin
        m_req   = 1'b1;
        m_wr    = 1'b1;
        m_size  = size_mem[head_q];
        m_addr  = addr_mem[head_q];
        m_wdata = wdata_mem[head_q];
      end
      RD_ADDR: begin
        m_req   = 1'b1;
        m_size  = rd_size_q;
        m_addr  = rd_addr_q;
      end
      default: ;
    endcase
  end

  // Write acks and the load completion never coincide: a load is only in
  // flight when no write was accepted the cycle before.
  assign s_data_ok = wack_q | ((state_q == RD_DATA) & m_data_ok);
  assign s_rdata   = (state_q == RD_DATA) ? m_rdata : 32'd0;
  assign drained   = (count_q == '0) && (state_q == IDLE);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q   <= IDLE;
      head_q    <= '0;
      tail_q    <= '0;
      count_q   <= '0;
      wack_q    <= 1'b0;
      rd_size_q <= 2'd0;
      rd_addr_q <= 32'd0;
    end else begin
      state_q   <= state_d;
      head_q    <= head_d;
      tail_q    <= tail_d;
      count_q   <= count_d;
      wack_q    <= wack_d;
      rd_size_q <= rd_size_d;
      rd_addr_q <= rd_addr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      size_mem[tail_q]  <= s_size;
      addr_mem[tail_q]  <= s_addr;
      wdata_mem[tail_q] <= s_wdata;
    end
  end

endmodule
